// File: rtl/pll_pkg.sv
// Shared definitions for the PLL phase-shift responder.
// Contents: phase-counter select codes, the handshake state encoding, the
// default counter width and step count, and a helper that turns a select
// code into a per-counter enable mask (bit 0 = M, bits 1..5 = C0..C4).
package pll_pkg;

  localparam int PW_DEF     = 8;
  localparam int NSTEPS_DEF = 64;

  localparam logic [2:0] SEL_ALL = 3'b000;
  localparam logic [2:0] SEL_M   = 3'b001;
  localparam logic [2:0] SEL_C0  = 3'b010;
  localparam logic [2:0] SEL_C1  = 3'b011;
  localparam logic [2:0] SEL_C2  = 3'b100;
  localparam logic [2:0] SEL_C3  = 3'b101;
  localparam logic [2:0] SEL_C4  = 3'b110;
  localparam logic [2:0] SEL_BAD = 3'b111;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY      = 2'd1,
    DONE_WAIT = 2'd2
  } state_e;

  // Select code to counter-enable mask; "all" covers C0..C4 only, never M.
  function automatic logic [5:0] sel_mask(input logic [2:0] sel);
    logic [5:0] m;
    case (sel)
      SEL_ALL: m = 6'b111110;
      SEL_M:   m = 6'b000001;
      SEL_C0:  m = 6'b000010;
      SEL_C1:  m = 6'b000100;
      SEL_C2:  m = 6'b001000;
      SEL_C3:  m = 6'b010000;
      SEL_C4:  m = 6'b100000;
      default: m = 6'b000000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/pll_phase_accum.sv
// One modulo-NSTEPS up/down phase-position counter.
// Ports:
//   clk_i  - clock
//   rst_i  - asynchronous active-high reset
//   clr_i  - synchronous clear to 0 (wins over en_i)
//   en_i   - apply one step this cycle
//   up_i   - step direction, 1 = up, 0 = down
//   pos_o  - current position, 0..NSTEPS-1
module pll_phase_accum #(
  parameter int PW     = 8,
  parameter int NSTEPS = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic          up_i,
  output logic [PW-1:0] pos_o
);

  localparam logic [PW-1:0] MAXPOS = PW'(NSTEPS - 1);

  logic [PW-1:0] pos_q;
  logic [PW-1:0] pos_d;

  // Next position: clear, wrap-around step, or hold.
  always_comb begin
    pos_d = pos_q;
    if (clr_i) begin
      pos_d = '0;
    end else if (en_i) begin
      if (up_i) begin
        pos_d = (pos_q == MAXPOS) ? '0 : pos_q + PW'(1);
      end else begin
        pos_d = (pos_q == '0) ? MAXPOS : pos_q - PW'(1);
      end
    end else begin
      pos_d = pos_q;
    end
  end

  // Position register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/pll_phase_responder.sv
// PLL-side responder for the dynamic phase-shift / clock-switch handshake.
// scanclk and clkswitch are sampled as data in the clk domain; their rising
// edges drive the handshake and the clock-source toggle.
// Ports:
//   clk, reset          - system clock, asynchronous active-high reset
//   pll_areset          - synchronous PLL reset (clears positions/source)
//   phasecounterselect  - counter select (000 all C, 001 M, 010..110 C0..C4)
//   phaseupdown         - step direction, 1 = up
//   phasestep           - step request
//   scanclk             - phase-shift clock
//   clkswitch           - clock-source toggle request
//   phase_done          - 1 = idle/complete, 0 = step in progress
//   active_clksrc       - 0 = inclk0, 1 = inclk1
//   phase_pos           - packed positions, M in the low slice, then C0..C4
//   step_count          - completed steps, wrapping
//   err_badsel          - sticky: a step completed with select 111
module pll_phase_responder
  import pll_pkg::*;
#(
  parameter int PW       = PW_DEF,
  parameter int NSTEPS   = NSTEPS_DEF,
  parameter int DONE_LAT = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pll_areset,
  input  logic [2:0]      phasecounterselect,
  input  logic            phaseupdown,
  input  logic            phasestep,
  input  logic            scanclk,
  input  logic            clkswitch,
  output logic            phase_done,
  output logic            active_clksrc,
  output logic [6*PW-1:0] phase_pos,
  output logic [15:0]     step_count,
  output logic            err_badsel
);

  localparam logic [3:0] LAT = 4'(DONE_LAT);

  state_e      state_q, state_d;
  logic        sc_q, cs_q;
  logic        armed_q, armed_d;
  logic [2:0]  sel_q, sel_d;
  logic        up_q, up_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        clksrc_q, clksrc_d;
  logic [15:0] steps_q, steps_d;
  logic        err_q, err_d;

  logic        sc_rise;
  logic        cs_rise;
  logic        apply_step;
  logic [5:0]  acc_en;

  assign sc_rise = scanclk & ~sc_q;
  assign cs_rise = clkswitch & ~cs_q;

  // Handshake FSM, arming, clock-source toggle and step bookkeeping.
  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    sel_d      = sel_q;
    up_d       = up_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    clksrc_d   = clksrc_q;
    steps_d    = steps_q;
    err_d      = err_q;
    apply_step = 1'b0;

    // A request must be seen low on a scanclk edge before another is taken.
    if (sc_rise && !phasestep) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end

    if (cs_rise) begin
      clksrc_d = ~clksrc_q;
    end else begin
      clksrc_d = clksrc_q;
    end

    case (state_q)
      IDLE: begin
        if (sc_rise && phasestep && armed_q) begin
          sel_d   = phasecounterselect;
          up_d    = phaseupdown;
          armed_d = 1'b0;
          cnt_d   = 4'd0;
          done_d  = 1'b0;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // Every scanclk edge counts toward the latency, whatever phasestep is.
        if (sc_rise) begin
          cnt_d = cnt_q + 4'd1;
          if ((cnt_q + 4'd1) == LAT) begin
            apply_step = 1'b1;
            done_d     = 1'b1;
            state_d    = DONE_WAIT;
          end else begin
            state_d = BUSY;
          end
        end else begin
          state_d = BUSY;
        end
      end
      DONE_WAIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    endcase

    // PLL reset abandons any step in flight and beats a same-cycle clkswitch.
    if (pll_areset) begin
      state_d    = IDLE;
      done_d     = 1'b1;
      clksrc_d   = 1'b0;
      armed_d    = 1'b0;
      apply_step = 1'b0;
    end else begin
      state_d = state_d;
    end

    if (apply_step) begin
      steps_d = steps_q + 16'd1;
      if (sel_q == SEL_BAD) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end else begin
      steps_d = steps_q;
    end
  end

  // Handshake and edge-detect registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sc_q     <= 1'b0;
      cs_q     <= 1'b0;
      armed_q  <= 1'b0;
      sel_q    <= 3'b000;
      up_q     <= 1'b0;
      cnt_q    <= 4'd0;
      done_q   <= 1'b1;
      clksrc_q <= 1'b0;
      steps_q  <= 16'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sc_q     <= scanclk;
      cs_q     <= clkswitch;
      armed_q  <= armed_d;
      sel_q    <= sel_d;
      up_q     <= up_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      clksrc_q <= clksrc_d;
      steps_q  <= steps_d;
      err_q    <= err_d;
    end
  end

  assign acc_en = sel_mask(sel_q) & {6{apply_step}};

  for (genvar i = 0; i < 6; i++) begin : g_acc
    pll_phase_accum #(
      .PW    (PW),
      .NSTEPS(NSTEPS)
    ) u_acc (
      .clk_i(clk),
      .rst_i(reset),
      .clr_i(pll_areset),
      .en_i (acc_en[i]),
      .up_i (up_q),
      .pos_o(phase_pos[i*PW +: PW])
    );
  end

  assign phase_done    = done_q;
  assign active_clksrc = clksrc_q;
  assign step_count    = steps_q;
  assign err_badsel    = err_q;

endmodule

// File: tb/tb_pll_phase_responder.sv
// Scoreboard bench for pll_phase_responder: stimulus pushes the expected
// post-completion state; a monitor pops it on every phase_done rising edge.
module tb_pll_phase_responder;

  localparam int PW       = 8;
  localparam int NSTEPS   = 64;
  localparam int DONE_LAT = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            pll_areset;
  logic [2:0]      phasecounterselect;
  logic            phaseupdown;
  logic            phasestep;
  logic            scanclk;
  logic            clkswitch;
  logic            phase_done;
  logic            active_clksrc;
  logic [6*PW-1:0] phase_pos;
  logic [15:0]     step_count;
  logic            err_badsel;

  pll_phase_responder #(.PW(PW), .NSTEPS(NSTEPS), .DONE_LAT(DONE_LAT)) dut (
    .clk(clk), .reset(reset), .pll_areset(pll_areset),
    .phasecounterselect(phasecounterselect), .phaseupdown(phaseupdown),
    .phasestep(phasestep), .scanclk(scanclk), .clkswitch(clkswitch),
    .phase_done(phase_done), .active_clksrc(active_clksrc),
    .phase_pos(phase_pos), .step_count(step_count), .err_badsel(err_badsel)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6*PW-1:0] pos;
    logic [15:0]     cnt;
    logic            err;
    logic            src;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: index 0 = M, 1..5 = C0..C4.
  int mpos[6];
  int mcnt;
  bit merr;
  bit msrc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [6*PW-1:0] pack_model();
    logic [6*PW-1:0] r;
    for (int i = 0; i < 6; i++) r[i*PW +: PW] = PW'(mpos[i]);
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 6; i++) mpos[i] = 0;
    msrc = 1'b0;
  endtask

  task automatic model_step(input int sel, input bit up);
    for (int i = 0; i < 6; i++) begin
      bit hit;
      hit = (sel == 0 && i >= 1) || (sel == 1 && i == 0) ||
            (sel >= 2 && sel <= 6 && i == sel - 1);
      if (hit) mpos[i] = up ? (mpos[i] + 1) % NSTEPS : (mpos[i] + NSTEPS - 1) % NSTEPS;
    end
    if (sel == 7) merr = 1'b1;
    mcnt = (mcnt + 1) % 65536;
  endtask

  task automatic push_expect();
    exp_t e;
    e.pos = pack_model();
    e.cnt = 16'(mcnt);
    e.err = merr;
    e.src = msrc;
    exp_q.push_back(e);
  endtask

  // Monitor: every completion (phase_done 0 -> 1) must match the next expectation.
  initial begin : monitor
    logic done_prev;
    exp_t e;
    done_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset && phase_done && !done_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_completion", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_phase_pos", 64'(phase_pos), 64'(e.pos));
          check("sb_step_count", 64'(step_count), 64'(e.cnt));
          check("sb_err_badsel", 64'(err_badsel), 64'(e.err));
          check("sb_clksrc", 64'(active_clksrc), 64'(e.src));
        end
      end
      done_prev = phase_done;
    end
  end

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // One scanclk rising edge seen with the given phasestep level.
  task automatic sc_edge(input bit ps);
    phasestep = ps;
    scanclk   = 1'b1;
    step_clk();
    scanclk   = 1'b0;
    step_clk();
    step_clk();
  endtask

  // Full step handshake; 'extra' further high edges after completion.
  task automatic do_step(input int sel, input bit up, input int extra, input bit chk);
    sc_edge(1'b0);
    phasecounterselect = 3'(sel);
    phaseupdown        = up;
    model_step(sel, up);
    push_expect();
    if (chk) check("done_before_accept", 64'(phase_done), 64'd1);
    phasestep = 1'b1;
    scanclk   = 1'b1;
    step_clk();
    if (chk) check("done_low_1clk", 64'(phase_done), 64'd0);
    scanclk = 1'b0;
    // Scramble the inputs: the latched request must be used.
    phasecounterselect = 3'($urandom_range(0, 7));
    phaseupdown        = 1'($urandom_range(0, 1));
    step_clk();
    step_clk();
    for (int k = 1; k <= DONE_LAT; k++) begin
      sc_edge(1'b1);
      if (chk) check($sformatf("done_after_edge%0d", k), 64'(phase_done), (k == DONE_LAT) ? 64'd1 : 64'd0);
    end
    for (int k = 0; k < extra; k++) begin
      sc_edge(1'b1);
      if (chk) check("done_held", 64'(phase_done), 64'd1);
    end
  endtask

  task automatic clk_switch();
    clkswitch = 1'b1;
    step_clk();
    clkswitch = 1'b0;
    step_clk();
    msrc = ~msrc;
  endtask

  // Abandon a step after one counted edge with a pll_areset pulse.
  task automatic abort_step(input int sel, input bit up);
    logic [15:0] cnt_before;
    sc_edge(1'b0);
    phasecounterselect = 3'(sel);
    phaseupdown        = up;
    sc_edge(1'b1);
    sc_edge(1'b1);
    check("abort_busy", 64'(phase_done), 64'd0);
    model_clear();
    push_expect();
    cnt_before = 16'(mcnt);
    pll_areset = 1'b1;
    step_clk();
    pll_areset = 1'b0;
    check("abort_done_next", 64'(phase_done), 64'd1);
    check("abort_pos_zero", 64'(phase_pos), 64'd0);
    // Still high after the abort: must not be taken as a new request.
    sc_edge(1'b1);
    check("no_rearm_done", 64'(phase_done), 64'd1);
    check("no_rearm_count", 64'(step_count), 64'(cnt_before));
  endtask

  initial begin
    reset = 1'b1; pll_areset = 1'b0; phasecounterselect = 3'b000;
    phaseupdown = 1'b0; phasestep = 1'b0; scanclk = 1'b0; clkswitch = 1'b0;
    model_clear(); mcnt = 0; merr = 1'b0;
    repeat (3) step_clk();
    reset = 1'b0;
    step_clk();
    check("rst_phase_done", 64'(phase_done), 64'd1);
    check("rst_clksrc", 64'(active_clksrc), 64'd0);
    check("rst_phase_pos", 64'(phase_pos), 64'd0);
    check("rst_step_count", 64'(step_count), 64'd0);
    check("rst_err", 64'(err_badsel), 64'd0);

    // Setter loop, phase 3: areset then 4 "all C" up-steps.
    pll_areset = 1'b1; step_clk(); pll_areset = 1'b0; step_clk();
    for (int i = 0; i < 4; i++) do_step(0, 1'b1, 0, 1'b1);
    check("setter_pos", 64'(phase_pos), 64'({{5{8'd4}}, 8'd0}));
    check("setter_count", 64'(step_count), 64'd4);
    check("setter_clksrc", 64'(active_clksrc), 64'd0);
    check("setter_err", 64'(err_badsel), 64'd0);

    // Setter with clksrc = 1: areset, then one clkswitch pulse.
    pll_areset = 1'b1; step_clk(); step_clk(); pll_areset = 1'b0;
    model_clear();
    clk_switch();
    check("setter_clksrc1", 64'(active_clksrc), 64'd1);
    check("setter_pos_cleared", 64'(phase_pos), 64'd0);
    check("setter_count_kept", 64'(step_count), 64'd4);

    // Areset and clkswitch together: reset wins.
    pll_areset = 1'b1; clkswitch = 1'b1; step_clk();
    pll_areset = 1'b0; clkswitch = 1'b0; step_clk();
    model_clear();
    check("areset_beats_switch", 64'(active_clksrc), 64'd0);

    // Down-step wrap on C0.
    do_step(2, 1'b0, 0, 1'b1);
    check("wrap_c0", 64'(phase_pos), 64'({32'd0, 8'd63, 8'd0}));

    // phasestep held over 10 edges: exactly one step.
    do_step(3, 1'b1, 10 - 1 - DONE_LAT, 1'b1);
    check("hold10_count", 64'(step_count), 64'd6);
    check("hold10_pos", 64'(phase_pos), 64'({24'd0, 8'd1, 8'd63, 8'd0}));

    // Invalid select.
    do_step(7, 1'b1, 0, 1'b1);
    check("bad_err", 64'(err_badsel), 64'd1);
    check("bad_pos", 64'(phase_pos), 64'(pack_model()));
    check("bad_count", 64'(step_count), 64'd7);

    abort_step(4, 1'b1);
    do_step(4, 1'b1, 0, 1'b1);

    // Randomised traffic.
    for (int it = 0; it < 40; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) abort_step($urandom_range(0, 7), 1'($urandom_range(0, 1)));
      else if (r == 1) begin
        clk_switch();
        check("rand_clksrc", 64'(active_clksrc), 64'(msrc));
      end
      else do_step($urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
    end
    check("final_pos", 64'(phase_pos), 64'(pack_model()));
    check("final_count", 64'(step_count), 64'(mcnt));
    check("final_err", 64'(err_badsel), 64'(merr));

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step_clk();
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pll_phase_responder.md
Name: pll_phase_responder

Overview:
- Synthesizable model of the PLL side of the dynamic phase-shift and clock-switch interface: the responder to pll_setter.
- Consumes areset, phasecounterselect, phaseupdown, phasestep, scanclk and clkswitch; produces phase_done.
- Tracks the accumulated phase position of each PLL counter and the active input-clock source.
- Lets the board bench and on-chip self-test close the loop on pll_setter without a vendor PLL model.

Parameters:
- PW, 8, width of each phase-position counter.
- NSTEPS, 64, phase steps per full rotation; positions wrap modulo NSTEPS (NSTEPS <= 2^PW).
- DONE_LAT, 2, rising scanclk edges after acceptance before phase_done returns high (1..15).

Ports:
- clk  input  1  system clock; the same clock that generates scanclk.
- reset  input  1  asynchronous, active-high reset.
- pll_areset  input  1  PLL reset from pll_setter (areset); synchronous to clk.
- phasecounterselect  input  3  000 = all C counters, 001 = M, 010..110 = C0..C4, 111 = invalid.
- phaseupdown  input  1  1 = up, 0 = down.
- phasestep  input  1  step request.
- scanclk  input  1  phase-shift clock, treated as data in the clk domain.
- clkswitch  input  1  clock-source toggle request.
- phase_done  output  1  high = idle/complete; low = step in progress.
- active_clksrc  output  1  0 = inclk0, 1 = inclk1.
- phase_pos  output  6*PW  packed positions: [PW-1:0] = M, then C0..C4 in ascending slices.
- step_count  output  16  number of completed steps; wraps at 2^16.
- err_badsel  output  1  sticky flag: a step was accepted with select 111.

Behaviour:
- Reset values (reset high): phase_done = 1, active_clksrc = 0, all phase_pos = 0, step_count = 0, err_badsel = 0, state IDLE, all internal edge registers = 0.
- Edge detection: sc_q <= scanclk each cycle. A scanclk rising edge (sc_rise) is scanclk & ~sc_q. A clkswitch rising edge is detected the same way.
- States:
  - IDLE -> BUSY: on sc_rise when phasestep = 1 and armed = 1. In that cycle, latch phasecounterselect and phaseupdown, clear armed, set edge count = 0.
  - phase_done is a registered output: it goes 0 the clk cycle after acceptance.
  - BUSY: each sc_rise increments the edge count. On the sc_rise that makes the count reach DONE_LAT, apply the step and set phase_done = 1 in the same clk cycle; next state DONE_WAIT.
  - DONE_WAIT -> IDLE: unconditional on the next clk cycle.
- Arming: armed is set on any sc_rise that sees phasestep = 0. One phasestep assertion produces exactly one step, however many scanclk edges it spans.
- Step application:
  - Up: pos = (pos == NSTEPS-1) ? 0 : pos+1.
  - Down: pos = (pos == 0) ? NSTEPS-1 : pos-1.
  - Select 000 steps C0..C4 together; M is unchanged.
  - Select 111: no position change, err_badsel <= 1. The handshake still completes normally.
  - step_count increments on every applied step, including select 111.
- clkswitch: each rising edge toggles active_clksrc, in any state.
- pll_areset high (any state, any cycle; highest priority after reset):
  - Cleared: phase_pos all 0, active_clksrc = 0, phase_done = 1, state = IDLE, armed = 0.
  - Preserved: step_count and err_badsel.
  - A step in progress is abandoned with no position change.
- Simultaneous events:
  - pll_areset together with clkswitch: the reset wins, so active_clksrc = 0.
  - sc_rise with phasestep = 1 while BUSY is not a new request; the edge only counts toward DONE_LAT.
- Minimum latency from acceptance to phase_done = 1 is DONE_LAT scanclk periods.

Decomposition:
- Shared package pll_pkg holds:
  - SEL_ALL = 3'b000, SEL_M = 3'b001, SEL_C0..SEL_C4 = 3'b010..3'b110, SEL_BAD = 3'b111;
  - the state encodings IDLE, BUSY, DONE_WAIT;
  - the default PW and NSTEPS.
- Sub-module pll_phase_accum: one modulo-NSTEPS up/down counter with inputs en, up and clr. Instantiate it 6 times.

Test Plan:
- Setter loop, pll_phase = 3, pll_clksrc = 0 -> 4 steps total (the setter's <= comparison gives phase+1 steps); C0..C4 = 4, M = 0, step_count = 4, active_clksrc = 0, err_badsel = 0.
- Setter loop with pll_clksrc = 1 -> one clkswitch pulse, active_clksrc = 1 after pll_areset has fallen.
- Down-step wrap: select 010 (C0), updown = 0, from position 0 -> C0 = 63, all other counters unchanged.
- phasestep held high for 10 rising scanclk edges -> exactly 1 step. phase_done goes low 1 clk after the first edge and high on the 2nd following edge (DONE_LAT = 2).
- Select 111 step -> err_badsel = 1, positions unchanged, step_count +1, phase_done completes.
- pll_areset pulsed while BUSY after 1 edge -> phase_done = 1 next cycle, positions 0, state IDLE. A new phasestep is accepted only after it has been seen low.
